llc_set_buf_pool: RTL and testbench
===================================

# llc_set_buf_pool

Parametrised pool of NBUF LLC set buffers, organised as an in-order queue. Each entry holds every way's line, tag, state, owner, sharers, hprot and dirty bit, plus an eviction-way pointer, for one set. A load handshake from the decoder/memory stage fills the tail entry. The LLC controller sees only the head entry, modifies it per way and field, and releases it. This lets set N+1 be captured while set N is still being processed.

## Interface
- WAYS, 16: ways per set, a power of 2 ≥ 2; WAY_BITS = $clog2(WAYS).
- NBUF, 2: number of set buffers, ≥ 1; CNT_BITS = $clog2(NBUF+1).
- LINE_BITS, 128; TAG_BITS, 20; STATE_BITS, 3; OWNER_BITS, 4; SHARERS_BITS, 16; HPROT_BITS, 1: field widths.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous and active-low.
- ld_valid  in  1  load request.
- ld_ready  out  1  pool can accept a load.
- ld_look  in  1  1: capture ld_* data; 0: allocate the entry all-zero.
- ld_line/ld_tag/ld_state/ld_owner/ld_sharers/ld_hprot/ld_dirty  in  WAYS×field  flattened localmem read data; way w occupies bits [w*W +: W].
- ld_evict_way  in  WAY_BITS  initial eviction pointer.
- wr_en  in  7  per-field write enable: bit0 line, 1 tag, 2 state, 3 owner, 4 sharers, 5 hprot, 6 dirty.
- wr_way  in  WAY_BITS  way targeted by wr_en.
- wr_line/wr_tag/wr_state/wr_owner/wr_sharers/wr_hprot/wr_dirty  in  field  write data.
- incr_evict  in  1  advance the head eviction pointer.
- clr  in  1  zero the head entry's contents; the entry stays allocated.
- rel  in  1  release (pop) the head entry.
- head_valid  out  1  head entry allocated.
- head_line/…/head_dirty  out  WAYS×field  flattened head contents.
- head_evict_way  out  WAY_BITS  head eviction pointer.
- count  out  CNT_BITS  allocated entries.

## Operation
- Storage is circular: rd_ptr is the head, wr_ptr is the tail, and count is tracked explicitly. Both pointers wrap from NBUF-1 to 0; non-power-of-2 NBUF is legal.
- ld_ready = (count != NBUF). It is registered-state only and has no combinational path from ld_valid or rel. There is no same-cycle bypass when full.
- Load fire (ld_valid && ld_ready) writes the entry at wr_ptr: all ways from ld_* and evict_way = ld_evict_way. If ld_look=0, all fields are written as 0. Then wr_ptr++.
- Head updates apply only when head_valid, and are otherwise ignored:
  - wr_en[k] writes field k of way wr_way. Fields are independent; any subset may be written in one cycle.
  - incr_evict: evict_way ← evict_way+1 mod WAYS (wraps WAYS-1 → 0).
  - clr zeroes all ways and evict_way. clr overrides wr_en and incr_evict in the same cycle.
  - rel: rd_ptr++. rel overrides clr, wr_en and incr_evict in the same cycle (those updates are dropped).
- Load fire and rel in the same cycle: count unchanged; both pointers advance.
- Load into an empty pool followed by rel in the next cycle is legal.
- head_* outputs are a mux of entry[rd_ptr]. When the pool is empty they show the stale entry; consumers must qualify with head_valid.

## Timing
- Reset (rst=0 at an edge): rd_ptr=wr_ptr=count=0 and all storage zeroed. Outputs after reset: head_valid=0, count=0, ld_ready=1, all head_* = 0. Reset mid-operation discards all entries within that edge.
- Load latency: a fire at edge t into an empty pool gives head_valid=1 with the loaded data after edge t.
- Head write, incr_evict, clr and rel each take effect at the same edge; results are visible on head_* the cycle after.
- Release latency: after rel at edge t, the next entry (if any) appears on head_* after edge t.
- Throughput: one load and one release per cycle.

## Structure
- Package llc_set_buf_pkg holds the field-select indices (FLD_LINE … FLD_DIRTY) and the flatten/unflatten helper functions. Widths stay module parameters.
- Sub-module llc_set_buf_entry holds one set: WAYS×fields plus evict_way, with load/write/incr/clr ports. NBUF instances are generated; the pool holds the pointers, count and head mux.

## Test plan
- Reset then idle: head_valid=0, count=0, ld_ready=1, head_evict_way=0.
- Load with look=1, tags = way index, evict_way=3, then incr_evict ×13: head_evict_way goes 3→…→15→0. With WAYS=16, evict_way=0 after the 13th increment.
- NBUF=2: load A and B back-to-back; a third ld_valid sees ld_ready=0 and count=2. rel → head shows B, ld_ready=1.
- Same cycle rel + load while count=1: count stays 1, head shows the new entry next cycle, and the tail wraps to 0.
- wr_en=7'b0000101 with wr_way=5 and clr in the same cycle: head all zero. Repeat without clr: only way 5 line and state change.
- rst=0 asserted with count=2 and wr_en active: next cycle count=0, head_valid=0, and all storage reads back 0 after a subsequent look=0 load.

Source files
------------

// File: rtl/llc_set_buf_pkg.sv
// Shared field-select indices and way-slice helpers for the LLC set buffer pool.
package llc_set_buf_pkg;
   localparam int NFLD      = 7;
   localparam int FLD_LINE  = 0;
   localparam int FLD_TAG   = 1;
   localparam int FLD_STATE = 2;
   localparam int FLD_OWNER = 3;
   localparam int FLD_SHARE = 4;
   localparam int FLD_HPROT = 5;
   localparam int FLD_DIRTY = 6;

   // Bit offset of a way inside a flattened WAYS x width vector (both directions).
   function automatic int way_off(input int way, input int width);
      return way * width;
   endfunction
endpackage

// File: rtl/llc_set_buf_entry.sv
// One LLC set buffer: every way's fields plus the eviction pointer.
module llc_set_buf_entry
   import llc_set_buf_pkg::*;
#(
   parameter int WAYS         = 16,
   parameter int WAY_BITS     = $clog2(WAYS),
   parameter int LINE_BITS    = 128,
   parameter int TAG_BITS     = 20,
   parameter int STATE_BITS   = 3,
   parameter int OWNER_BITS   = 4,
   parameter int SHARERS_BITS = 16,
   parameter int HPROT_BITS   = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         ld_en_i,
   input  logic                         ld_look_i,
   input  logic [WAYS*LINE_BITS-1:0]    ld_line_i,
   input  logic [WAYS*TAG_BITS-1:0]     ld_tag_i,
   input  logic [WAYS*STATE_BITS-1:0]   ld_state_i,
   input  logic [WAYS*OWNER_BITS-1:0]   ld_owner_i,
   input  logic [WAYS*SHARERS_BITS-1:0] ld_sharers_i,
   input  logic [WAYS*HPROT_BITS-1:0]   ld_hprot_i,
   input  logic [WAYS-1:0]              ld_dirty_i,
   input  logic [WAY_BITS-1:0]          ld_evict_way_i,
   input  logic [NFLD-1:0]              wr_en_i,
   input  logic [WAY_BITS-1:0]          wr_way_i,
   input  logic [LINE_BITS-1:0]         wr_line_i,
   input  logic [TAG_BITS-1:0]          wr_tag_i,
   input  logic [STATE_BITS-1:0]        wr_state_i,
   input  logic [OWNER_BITS-1:0]        wr_owner_i,
   input  logic [SHARERS_BITS-1:0]      wr_sharers_i,
   input  logic [HPROT_BITS-1:0]        wr_hprot_i,
   input  logic                         wr_dirty_i,
   input  logic                         incr_evict_i,
   input  logic                         clr_i,
   output logic [WAYS*LINE_BITS-1:0]    line_o,
   output logic [WAYS*TAG_BITS-1:0]     tag_o,
   output logic [WAYS*STATE_BITS-1:0]   state_o,
   output logic [WAYS*OWNER_BITS-1:0]   owner_o,
   output logic [WAYS*SHARERS_BITS-1:0] sharers_o,
   output logic [WAYS*HPROT_BITS-1:0]   hprot_o,
   output logic [WAYS-1:0]              dirty_o,
   output logic [WAY_BITS-1:0]          evict_way_o
);
   logic [WAYS*LINE_BITS-1:0]    line_q, line_d;
   logic [WAYS*TAG_BITS-1:0]     tag_q, tag_d;
   logic [WAYS*STATE_BITS-1:0]   state_q, state_d;
   logic [WAYS*OWNER_BITS-1:0]   owner_q, owner_d;
   logic [WAYS*SHARERS_BITS-1:0] sharers_q, sharers_d;
   logic [WAYS*HPROT_BITS-1:0]   hprot_q, hprot_d;
   logic [WAYS-1:0]              dirty_q, dirty_d;
   logic [WAY_BITS-1:0]          evict_q, evict_d;

   // Priority: load, then clear, then per-field writes and pointer increment.
   always_comb begin
      line_d    = line_q;
      tag_d     = tag_q;
      state_d   = state_q;
      owner_d   = owner_q;
      sharers_d = sharers_q;
      hprot_d   = hprot_q;
      dirty_d   = dirty_q;
      evict_d   = evict_q;
      if (ld_en_i) begin
         line_d    = ld_look_i ? ld_line_i    : '0;
         tag_d     = ld_look_i ? ld_tag_i     : '0;
         state_d   = ld_look_i ? ld_state_i   : '0;
         owner_d   = ld_look_i ? ld_owner_i   : '0;
         sharers_d = ld_look_i ? ld_sharers_i : '0;
         hprot_d   = ld_look_i ? ld_hprot_i   : '0;
         dirty_d   = ld_look_i ? ld_dirty_i   : '0;
         evict_d   = ld_look_i ? ld_evict_way_i : '0;
      end else if (clr_i) begin
         line_d    = '0;
         tag_d     = '0;
         state_d   = '0;
         owner_d   = '0;
         sharers_d = '0;
         hprot_d   = '0;
         dirty_d   = '0;
         evict_d   = '0;
      end else begin
         if (wr_en_i[FLD_LINE])
            line_d[way_off(int'(wr_way_i), LINE_BITS) +: LINE_BITS] = wr_line_i;
         if (wr_en_i[FLD_TAG])
            tag_d[way_off(int'(wr_way_i), TAG_BITS) +: TAG_BITS] = wr_tag_i;
         if (wr_en_i[FLD_STATE])
            state_d[way_off(int'(wr_way_i), STATE_BITS) +: STATE_BITS] = wr_state_i;
         if (wr_en_i[FLD_OWNER])
            owner_d[way_off(int'(wr_way_i), OWNER_BITS) +: OWNER_BITS] = wr_owner_i;
         if (wr_en_i[FLD_SHARE])
            sharers_d[way_off(int'(wr_way_i), SHARERS_BITS) +: SHARERS_BITS] = wr_sharers_i;
         if (wr_en_i[FLD_HPROT])
            hprot_d[way_off(int'(wr_way_i), HPROT_BITS) +: HPROT_BITS] = wr_hprot_i;
         if (wr_en_i[FLD_DIRTY])
            dirty_d[wr_way_i] = wr_dirty_i;
         if (incr_evict_i)
            evict_d = evict_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         line_q    <= '0;
         tag_q     <= '0;
         state_q   <= '0;
         owner_q   <= '0;
         sharers_q <= '0;
         hprot_q   <= '0;
         dirty_q   <= '0;
         evict_q   <= '0;
      end else begin
         line_q    <= line_d;
         tag_q     <= tag_d;
         state_q   <= state_d;
         owner_q   <= owner_d;
         sharers_q <= sharers_d;
         hprot_q   <= hprot_d;
         dirty_q   <= dirty_d;
         evict_q   <= evict_d;
      end
   end

   assign line_o      = line_q;
   assign tag_o       = tag_q;
   assign state_o     = state_q;
   assign owner_o     = owner_q;
   assign sharers_o   = sharers_q;
   assign hprot_o     = hprot_q;
   assign dirty_o     = dirty_q;
   assign evict_way_o = evict_q;
endmodule

// File: rtl/llc_set_buf_pool.sv
// In-order pool of NBUF set buffers: loads fill the tail, the controller edits and pops the head.
module llc_set_buf_pool
   import llc_set_buf_pkg::*;
#(
   parameter int WAYS         = 16,
   parameter int NBUF         = 2,
   parameter int LINE_BITS    = 128,
   parameter int TAG_BITS     = 20,
   parameter int STATE_BITS   = 3,
   parameter int OWNER_BITS   = 4,
   parameter int SHARERS_BITS = 16,
   parameter int HPROT_BITS   = 1,
   parameter int WAY_BITS     = $clog2(WAYS),
   parameter int CNT_BITS     = $clog2(NBUF+1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ld_valid,
   output logic                         ld_ready,
   input  logic                         ld_look,
   input  logic [WAYS*LINE_BITS-1:0]    ld_line,
   input  logic [WAYS*TAG_BITS-1:0]     ld_tag,
   input  logic [WAYS*STATE_BITS-1:0]   ld_state,
   input  logic [WAYS*OWNER_BITS-1:0]   ld_owner,
   input  logic [WAYS*SHARERS_BITS-1:0] ld_sharers,
   input  logic [WAYS*HPROT_BITS-1:0]   ld_hprot,
   input  logic [WAYS-1:0]              ld_dirty,
   input  logic [WAY_BITS-1:0]          ld_evict_way,
   input  logic [NFLD-1:0]              wr_en,
   input  logic [WAY_BITS-1:0]          wr_way,
   input  logic [LINE_BITS-1:0]         wr_line,
   input  logic [TAG_BITS-1:0]          wr_tag,
   input  logic [STATE_BITS-1:0]        wr_state,
   input  logic [OWNER_BITS-1:0]        wr_owner,
   input  logic [SHARERS_BITS-1:0]      wr_sharers,
   input  logic [HPROT_BITS-1:0]        wr_hprot,
   input  logic                         wr_dirty,
   input  logic                         incr_evict,
   input  logic                         clr,
   input  logic                         rel,
   output logic                         head_valid,
   output logic [WAYS*LINE_BITS-1:0]    head_line,
   output logic [WAYS*TAG_BITS-1:0]     head_tag,
   output logic [WAYS*STATE_BITS-1:0]   head_state,
   output logic [WAYS*OWNER_BITS-1:0]   head_owner,
   output logic [WAYS*SHARERS_BITS-1:0] head_sharers,
   output logic [WAYS*HPROT_BITS-1:0]   head_hprot,
   output logic [WAYS-1:0]              head_dirty,
   output logic [WAY_BITS-1:0]          head_evict_way,
   output logic [CNT_BITS-1:0]          count
);
   localparam int PTR_BITS = (NBUF > 1) ? $clog2(NBUF) : 1;

   logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_BITS-1:0] count_q, count_d;
   logic                ld_fire, rel_fire;

   logic [WAYS*LINE_BITS-1:0]    ent_line    [NBUF];
   logic [WAYS*TAG_BITS-1:0]     ent_tag     [NBUF];
   logic [WAYS*STATE_BITS-1:0]   ent_state   [NBUF];
   logic [WAYS*OWNER_BITS-1:0]   ent_owner   [NBUF];
   logic [WAYS*SHARERS_BITS-1:0] ent_sharers [NBUF];
   logic [WAYS*HPROT_BITS-1:0]   ent_hprot   [NBUF];
   logic [WAYS-1:0]              ent_dirty   [NBUF];
   logic [WAY_BITS-1:0]          ent_evict   [NBUF];

   function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
      return (p == PTR_BITS'(NBUF-1)) ? '0 : p + 1'b1;
   endfunction

   assign ld_ready   = (count_q != CNT_BITS'(NBUF));
   assign head_valid = (count_q != '0);
   assign ld_fire    = ld_valid && ld_ready;
   assign rel_fire   = rel && head_valid;

   always_comb begin
      rd_ptr_d = rel_fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = ld_fire  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      count_d  = count_q;
      if (ld_fire && !rel_fire)      count_d = count_q + 1'b1;
      else if (!ld_fire && rel_fire) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Head edits reach only the head entry, and a release in the same cycle drops them.
   for (genvar i = 0; i < NBUF; i++) begin : g_ent
      logic hsel;
      assign hsel = head_valid && !rel && (rd_ptr_q == PTR_BITS'(i));

      llc_set_buf_entry #(
         .WAYS(WAYS), .WAY_BITS(WAY_BITS), .LINE_BITS(LINE_BITS), .TAG_BITS(TAG_BITS),
         .STATE_BITS(STATE_BITS), .OWNER_BITS(OWNER_BITS), .SHARERS_BITS(SHARERS_BITS),
         .HPROT_BITS(HPROT_BITS)
      ) u_ent (
         .clk_i(clk), .rst_i(rst),
         .ld_en_i(ld_fire && (wr_ptr_q == PTR_BITS'(i))), .ld_look_i(ld_look),
         .ld_line_i(ld_line), .ld_tag_i(ld_tag), .ld_state_i(ld_state), .ld_owner_i(ld_owner),
         .ld_sharers_i(ld_sharers), .ld_hprot_i(ld_hprot), .ld_dirty_i(ld_dirty),
         .ld_evict_way_i(ld_evict_way),
         .wr_en_i(wr_en & {NFLD{hsel}}), .wr_way_i(wr_way), .wr_line_i(wr_line),
         .wr_tag_i(wr_tag), .wr_state_i(wr_state), .wr_owner_i(wr_owner),
         .wr_sharers_i(wr_sharers), .wr_hprot_i(wr_hprot), .wr_dirty_i(wr_dirty),
         .incr_evict_i(incr_evict && hsel), .clr_i(clr && hsel),
         .line_o(ent_line[i]), .tag_o(ent_tag[i]), .state_o(ent_state[i]),
         .owner_o(ent_owner[i]), .sharers_o(ent_sharers[i]), .hprot_o(ent_hprot[i]),
         .dirty_o(ent_dirty[i]), .evict_way_o(ent_evict[i])
      );
   end

   assign head_line      = ent_line[rd_ptr_q];
   assign head_tag       = ent_tag[rd_ptr_q];
   assign head_state     = ent_state[rd_ptr_q];
   assign head_owner     = ent_owner[rd_ptr_q];
   assign head_sharers   = ent_sharers[rd_ptr_q];
   assign head_hprot     = ent_hprot[rd_ptr_q];
   assign head_dirty     = ent_dirty[rd_ptr_q];
   assign head_evict_way = ent_evict[rd_ptr_q];
   assign count          = count_q;
endmodule

// File: tb/tb_llc_set_buf_pool.sv
// Directed self-checking bench for llc_set_buf_pool with WAYS=16, NBUF=2.
module tb_llc_set_buf_pool;
   localparam int WAYS = 16;
   localparam int NBUF = 2;
   localparam int WB = 4;
   localparam int CB = 2;

   logic clk = 1'b0;
   logic rst, ld_valid, ld_ready, ld_look;
   logic [WAYS*128-1:0] ld_line, head_line;
   logic [WAYS*20-1:0]  ld_tag, head_tag;
   logic [WAYS*3-1:0]   ld_state, head_state;
   logic [WAYS*4-1:0]   ld_owner, head_owner;
   logic [WAYS*16-1:0]  ld_sharers, head_sharers;
   logic [WAYS-1:0]     ld_hprot, head_hprot, ld_dirty, head_dirty;
   logic [WB-1:0]       ld_evict_way, wr_way, head_evict_way;
   logic [6:0]          wr_en;
   logic [127:0]        wr_line;
   logic [19:0]         wr_tag;
   logic [2:0]          wr_state;
   logic [3:0]          wr_owner;
   logic [15:0]         wr_sharers;
   logic [0:0]          wr_hprot;
   logic                wr_dirty, incr_evict, clr, rel, head_valid;
   logic [CB-1:0]       count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   llc_set_buf_pool #(.WAYS(WAYS), .NBUF(NBUF)) dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_look(ld_look),
      .ld_line(ld_line), .ld_tag(ld_tag), .ld_state(ld_state), .ld_owner(ld_owner),
      .ld_sharers(ld_sharers), .ld_hprot(ld_hprot), .ld_dirty(ld_dirty),
      .ld_evict_way(ld_evict_way), .wr_en(wr_en), .wr_way(wr_way), .wr_line(wr_line),
      .wr_tag(wr_tag), .wr_state(wr_state), .wr_owner(wr_owner), .wr_sharers(wr_sharers),
      .wr_hprot(wr_hprot), .wr_dirty(wr_dirty), .incr_evict(incr_evict), .clr(clr),
      .rel(rel), .head_valid(head_valid), .head_line(head_line), .head_tag(head_tag),
      .head_state(head_state), .head_owner(head_owner), .head_sharers(head_sharers),
      .head_hprot(head_hprot), .head_dirty(head_dirty), .head_evict_way(head_evict_way),
      .count(count)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ld_valid = 0; wr_en = '0; incr_evict = 0; clr = 0; rel = 0;
   endtask

   // Way w gets tag base+w; other fields are derived from w so every way differs.
   task automatic set_ld(input logic look, input logic [19:0] base, input logic [WB-1:0] ev);
      ld_look = look;
      ld_evict_way = ev;
      for (int w = 0; w < WAYS; w++) begin
         ld_line[w*128 +: 128]  = {base, 108'(w + 1)};
         ld_tag[w*20 +: 20]     = base + 20'(w);
         ld_state[w*3 +: 3]     = 3'(w);
         ld_owner[w*4 +: 4]     = 4'(w);
         ld_sharers[w*16 +: 16] = 16'(1) << w;
         ld_hprot[w]            = w[0];
         ld_dirty[w]            = ~w[0];
      end
   endtask

   task automatic test_reset();
      rst = 0; idle(); cyc(); cyc(); rst = 1;
      n_cmp++; if (head_valid !== 1'b0) begin n_err++; $display("FAIL reset_head_valid got %0b want 0", head_valid); end
      n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
      n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_ld_ready got %0b want 1", ld_ready); end
      n_cmp++; if (head_evict_way !== 4'd0) begin n_err++; $display("FAIL reset_evict got %0d want 0", head_evict_way); end
      n_cmp++; if (head_line !== '0) begin n_err++; $display("FAIL reset_head_line not zero"); end
   endtask

   task automatic test_evict_wrap();
      set_ld(1, 20'd0, 4'd3); ld_valid = 1; cyc(); ld_valid = 0;
      n_cmp++; if (head_valid !== 1'b1) begin n_err++; $display("FAIL load_head_valid got %0b want 1", head_valid); end
      n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL load_count got %0d want 1", count); end
      n_cmp++; if (head_tag[7*20 +: 20] !== 20'd7) begin n_err++; $display("FAIL load_tag7 got %0h want 7", head_tag[7*20 +: 20]); end
      n_cmp++; if (head_sharers[9*16 +: 16] !== 16'h0200) begin n_err++; $display("FAIL load_sharers9 got %0h want 0200", head_sharers[9*16 +: 16]); end
      n_cmp++; if (head_evict_way !== 4'd3) begin n_err++; $display("FAIL load_evict got %0d want 3", head_evict_way); end
      for (int i = 1; i <= 13; i++) begin
         incr_evict = 1; cyc();
         n_cmp++;
         if (head_evict_way !== 4'((3 + i) % 16)) begin
            n_err++; $display("FAIL incr_evict_%0d got %0d want %0d", i, head_evict_way, (3 + i) % 16);
         end
      end
      incr_evict = 0; rel = 1; cyc(); rel = 0;
      n_cmp++; if (head_valid !== 1'b0 || count !== 2'd0) begin n_err++; $display("FAIL evict_rel got v=%0b c=%0d want v=0 c=0", head_valid, count); end
   endtask

   task automatic test_full();
      set_ld(1, 20'hA0, 4'd1); ld_valid = 1; cyc();
      set_ld(1, 20'hB0, 4'd2); cyc();
      n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL full_ld_ready got %0b want 0", ld_ready); end
      n_cmp++; if (count !== 2'd2) begin n_err++; $display("FAIL full_count got %0d want 2", count); end
      set_ld(1, 20'hC0, 4'd3); cyc(); ld_valid = 0;
      n_cmp++; if (count !== 2'd2) begin n_err++; $display("FAIL full_noaccept_count got %0d want 2", count); end
      n_cmp++; if (head_tag[19:0] !== 20'hA0) begin n_err++; $display("FAIL full_head_A got %0h want a0", head_tag[19:0]); end
      rel = 1; cyc(); rel = 0;
      n_cmp++; if (head_tag[19:0] !== 20'hB0) begin n_err++; $display("FAIL rel_head_B got %0h want b0", head_tag[19:0]); end
      n_cmp++; if (head_evict_way !== 4'd2) begin n_err++; $display("FAIL rel_evict_B got %0d want 2", head_evict_way); end
      n_cmp++; if (ld_ready !== 1'b1 || count !== 2'd1) begin n_err++; $display("FAIL rel_ready_count got r=%0b c=%0d want r=1 c=1", ld_ready, count); end
   endtask

   task automatic test_rel_load();
      set_ld(1, 20'hD0, 4'd4); ld_valid = 1; rel = 1; cyc(); rel = 0;
      n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL rel_load_count got %0d want 1", count); end
      n_cmp++; if (head_tag[3*20 +: 20] !== 20'hD3) begin n_err++; $display("FAIL rel_load_head_D got %0h want d3", head_tag[3*20 +: 20]); end
      set_ld(1, 20'hE0, 4'd5); cyc(); ld_valid = 0;
      n_cmp++; if (count !== 2'd2 || head_tag[19:0] !== 20'hD0) begin n_err++; $display("FAIL wrap_load got c=%0d tag=%0h want c=2 tag=d0", count, head_tag[19:0]); end
      rel = 1; cyc();
      n_cmp++; if (head_tag[19:0] !== 20'hE0 || head_evict_way !== 4'd5) begin n_err++; $display("FAIL wrap_head_E got tag=%0h ev=%0d want e0 5", head_tag[19:0], head_evict_way); end
      cyc(); rel = 0;
      n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL drain_count got %0d want 0", count); end
   endtask

   task automatic test_clr_wr();
      logic [WAYS*128-1:0] exp_line;
      logic [WAYS*3-1:0]   exp_state;
      set_ld(1, 20'hF0, 4'd7); ld_valid = 1; cyc(); ld_valid = 0;
      wr_en = 7'b0000101; wr_way = 4'd5; wr_line = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
      wr_state = 3'd5; wr_tag = 20'h12345; wr_owner = 4'hF; clr = 1; incr_evict = 1; cyc(); clr = 0; incr_evict = 0;
      n_cmp++; if (head_line !== '0 || head_tag !== '0 || head_state !== '0) begin n_err++; $display("FAIL clr_override not all zero, line5=%0h state=%0h", head_line[5*128 +: 128], head_state); end
      n_cmp++; if (head_evict_way !== 4'd0 || head_valid !== 1'b1) begin n_err++; $display("FAIL clr_evict got ev=%0d v=%0b want 0 1", head_evict_way, head_valid); end
      cyc(); wr_en = '0;
      exp_line = '0; exp_line[5*128 +: 128] = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
      exp_state = '0; exp_state[5*3 +: 3] = 3'd5;
      n_cmp++; if (head_line !== exp_line) begin n_err++; $display("FAIL wr_line5 got %0h want %0h", head_line[5*128 +: 128], exp_line[5*128 +: 128]); end
      n_cmp++; if (head_state !== exp_state) begin n_err++; $display("FAIL wr_state got %0h want %0h", head_state, exp_state); end
      n_cmp++; if (head_tag !== '0 || head_owner !== '0) begin n_err++; $display("FAIL wr_untouched tag5=%0h owner=%0h want 0", head_tag[5*20 +: 20], head_owner); end
      wr_en = 7'h7F; incr_evict = 1; clr = 1; rel = 1; cyc(); idle();
      n_cmp++; if (head_valid !== 1'b0 || count !== 2'd0) begin n_err++; $display("FAIL rel_override got v=%0b c=%0d want 0 0", head_valid, count); end
   endtask

   task automatic test_reset_mid();
      set_ld(1, 20'h10, 4'd8); ld_valid = 1; cyc();
      set_ld(1, 20'h20, 4'd9); cyc();
      n_cmp++; if (count !== 2'd2) begin n_err++; $display("FAIL pre_reset_count got %0d want 2", count); end
      rst = 0; wr_en = 7'h7F; wr_way = 4'd2; wr_tag = 20'hFFFFF; cyc(); rst = 1; idle();
      n_cmp++; if (count !== 2'd0 || head_valid !== 1'b0 || ld_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset got c=%0d v=%0b r=%0b want 0 0 1", count, head_valid, ld_ready); end
      n_cmp++; if (head_tag !== '0) begin n_err++; $display("FAIL mid_reset_storage tag0=%0h want 0", head_tag[19:0]); end
      set_ld(0, 20'h30, 4'd9); ld_valid = 1; cyc(); ld_valid = 0;
      n_cmp++; if (head_valid !== 1'b1) begin n_err++; $display("FAIL look0_valid got %0b want 1", head_valid); end
      n_cmp++; if (head_line !== '0 || head_tag !== '0 || head_sharers !== '0 || head_dirty !== '0 || head_hprot !== '0) begin
         n_err++; $display("FAIL look0_zero tag0=%0h dirty=%0h", head_tag[19:0], head_dirty); end
      n_cmp++; if (head_evict_way !== 4'd0) begin n_err++; $display("FAIL look0_evict got %0d want 0", head_evict_way); end
   endtask

   initial begin
      rst = 0; idle(); ld_look = 0; ld_line = '0; ld_tag = '0; ld_state = '0; ld_owner = '0;
      ld_sharers = '0; ld_hprot = '0; ld_dirty = '0; ld_evict_way = '0; wr_way = '0;
      wr_line = '0; wr_tag = '0; wr_state = '0; wr_owner = '0; wr_sharers = '0;
      wr_hprot = '0; wr_dirty = 0;
      test_reset();
      test_evict_wrap();
      test_full();
      test_rel_load();
      test_clr_wr();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
